// File: rtl/xcvr_pll_pkg.sv
// xcvr_pll_pkg: shared channel state, CNT_SEL width and qualify-counter sizing
package xcvr_pll_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, QUAL, LOCKED} chan_state_e;
    localparam int CNT_SEL_W = 3;
    localparam int MAX_PLL = 1 << CNT_SEL_W;
    function automatic int qual_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/xcvr_pll_lock_chan.sv
// xcvr_pll_lock_chan: one PLL's synchroniser, lock-qualify FSM and loss-of-lock statistics; WAIT timeout under PLL_LOCK_TIMEOUT_EN
module xcvr_pll_lock_chan
    import xcvr_pll_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CNT_W = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             enable,
    input  logic             clr,
    output logic             lane_reset,
    output logic             is_locked,
    output logic             lol_flag,
    output logic [CNT_W-1:0] lol_cnt,
    output logic             stuck
);
    localparam int QW = qual_w(LOCK_STABLE_CYCLES);
    localparam logic [QW-1:0] QMAX = QW'(LOCK_STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    if (LOCK_STABLE_CYCLES < 2) begin : g_bad_stable
        $error("LOCK_STABLE_CYCLES must be at least 2");
    end

    logic [1:0] sync;
    logic lock_s, lol_ev;
    chan_state_e state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;

    assign lock_s = sync[1];
    assign is_locked = state == LOCKED;

    // Next state: enable dominates; a drop while LOCKED is the only LOL source
    always_comb begin
        state_n = state;
        qcnt_n = '0;
        lol_ev = 1'b0;
        if (!enable) state_n = IDLE;
        else case (state)
            IDLE: state_n = WAIT;
            WAIT: state_n = lock_s ? QUAL : WAIT;
            QUAL: begin
                state_n = !lock_s ? WAIT : (qcnt == QMAX) ? LOCKED : QUAL;
                qcnt_n = (lock_s && qcnt != QMAX) ? qcnt + QW'(1) : '0;
            end
            LOCKED: begin
                state_n = lock_s ? LOCKED : WAIT;
                lol_ev = !lock_s;
            end
            default: state_n = IDLE;
        endcase
    end

    // Synchroniser, state, qualify counter, lane reset from next state, sticky flag and saturating count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            state <= IDLE;
            qcnt <= '0;
            lane_reset <= 1'b1;
            lol_flag <= 1'b0;
            lol_cnt <= '0;
        end else begin
            sync <= {sync[0], pll_lock};
            state <= state_n;
            qcnt <= qcnt_n;
            lane_reset <= state_n != LOCKED;
            lol_flag <= lol_ev | (lol_flag & ~clr);
            lol_cnt <= clr ? CNT_W'(lol_ev) : (lol_ev && lol_cnt != CMAX) ? lol_cnt + CNT_W'(1) : lol_cnt;
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wcnt;

    // WAIT dwell counter saturates so STUCK is raised once per WAIT visit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
            stuck <= 1'b0;
        end else begin
            wcnt <= (state != WAIT) ? '0 : (wcnt == TW'(TIMEOUT_CYCLES)) ? wcnt : wcnt + TW'(1);
            stuck <= (state == WAIT && wcnt == TW'(TIMEOUT_CYCLES - 1)) | (stuck & ~clr);
        end
    end
`else
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    assign stuck = 1'b0;
`endif
endmodule

// File: rtl/xcvr_pll_lock_mgr.sv
// xcvr_pll_lock_mgr: N-channel TX PLL lock manager with all-locked status and LOL counter readout; STUCK timeout under PLL_LOCK_TIMEOUT_EN
module xcvr_pll_lock_mgr
    import xcvr_pll_pkg::*;
#(
    parameter int N_PLL = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CNT_W = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_PLL-1:0]     PLL_LOCK,
    input  logic [N_PLL-1:0]     PLL_ENABLE,
    input  logic                 CLR,
    input  logic [CNT_SEL_W-1:0] CNT_SEL,
    output logic [N_PLL-1:0]     LANE_RESET,
    output logic                 ALL_LOCKED,
    output logic [N_PLL-1:0]     LOL_FLAG,
    output logic [CNT_W-1:0]     LOL_COUNT,
    output logic [N_PLL-1:0]     STUCK
);
    if (N_PLL < 1 || N_PLL > MAX_PLL) begin : g_bad_n
        $error("N_PLL must be in 1..8");
    end

    logic [N_PLL-1:0] locked;
    logic [CNT_W-1:0] cnt [MAX_PLL];

    for (genvar g = 0; g < MAX_PLL; g++) begin : g_chan
        if (g < N_PLL) begin : g_on
            xcvr_pll_lock_chan #(
                .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
                .CNT_W(CNT_W),
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_chan (
                .clk(CLK),
                .rst(RESET),
                .pll_lock(PLL_LOCK[g]),
                .enable(PLL_ENABLE[g]),
                .clr(CLR),
                .lane_reset(LANE_RESET[g]),
                .is_locked(locked[g]),
                .lol_flag(LOL_FLAG[g]),
                .lol_cnt(cnt[g]),
                .stuck(STUCK[g])
            );
        end else begin : g_off
            assign cnt[g] = '0;
        end
    end

    // Aggregate lock over enabled channels and registered counter readout; unused selects read 0
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ALL_LOCKED <= 1'b0;
            LOL_COUNT <= '0;
        end else begin
            ALL_LOCKED <= |PLL_ENABLE && &(locked | ~PLL_ENABLE);
            LOL_COUNT <= cnt[CNT_SEL];
        end
    end
endmodule

// File: tb/tb_xcvr_pll_lock_mgr.sv
// tb_xcvr_pll_lock_mgr: directed bench with a run-length lock model checked every cycle plus literal expectations
module tb_xcvr_pll_lock_mgr;
    localparam int N = 2;
    localparam int L = 16;
    localparam int W = 2;
    localparam int T = 100;
    localparam int CMAX = (1 << W) - 1;
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic [N-1:0] PLL_LOCK = '0;
    logic [N-1:0] PLL_ENABLE = '0;
    logic CLR = 1'b0;
    logic [2:0] CNT_SEL = '0;
    logic [N-1:0] LANE_RESET, LOL_FLAG, STUCK;
    logic ALL_LOCKED;
    logic [W-1:0] LOL_COUNT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    xcvr_pll_lock_mgr #(
        .N_PLL(N),
        .LOCK_STABLE_CYCLES(L),
        .CNT_W(W),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .PLL_LOCK(PLL_LOCK),
        .PLL_ENABLE(PLL_ENABLE),
        .CLR(CLR),
        .CNT_SEL(CNT_SEL),
        .LANE_RESET(LANE_RESET),
        .ALL_LOCKED(ALL_LOCKED),
        .LOL_FLAG(LOL_FLAG),
        .LOL_COUNT(LOL_COUNT),
        .STUCK(STUCK)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Model: run = consecutive synchronised-high cycles seen while active; locked when run reaches L
    logic [N-1:0] s1 = '0, s2 = '0;
    int run [N];
    int wc [N];
    int cnt [N];
    bit act [N];
    bit flag [N];
    bit stk [N];
    logic [N-1:0] m_lr = '1;
    logic m_all = 1'b0;
    int m_lc = 0;

    always @(posedge CLK or posedge RESET) begin
        bit any_en, all_lk, ev, waiting;
        if (RESET) begin
            s1 = '0;
            s2 = '0;
            m_lr = '1;
            m_all = 1'b0;
            m_lc = 0;
            for (int i = 0; i < N; i++) begin
                run[i] = 0; wc[i] = 0; cnt[i] = 0; act[i] = 0; flag[i] = 0; stk[i] = 0;
            end
        end else begin
            any_en = 0;
            all_lk = 1;
            for (int i = 0; i < N; i++)
                if (PLL_ENABLE[i]) begin
                    any_en = 1;
                    if (run[i] < L) all_lk = 0;
                end
            m_all = any_en && all_lk;
            m_lc = (CNT_SEL < N) ? cnt[CNT_SEL] : 0;
            for (int i = 0; i < N; i++) begin
                ev = 0;
                waiting = act[i] && run[i] == 0;
                if (!PLL_ENABLE[i]) begin
                    act[i] = 0;
                    run[i] = 0;
                end else if (!act[i]) begin
                    act[i] = 1;
                    run[i] = 0;
                end else if (s2[i]) begin
                    run[i] = (run[i] >= L) ? L : run[i] + 1;
                end else begin
                    ev = run[i] >= L;
                    run[i] = 0;
                end
                if (CLR) cnt[i] = ev ? 1 : 0;
                else if (ev && cnt[i] < CMAX) cnt[i] = cnt[i] + 1;
                flag[i] = ev | (flag[i] & !CLR);
                if (TO) begin
                    wc[i] = waiting ? wc[i] + 1 : 0;
                    stk[i] = (waiting && wc[i] == T) | (stk[i] & !CLR);
                end
                m_lr[i] = run[i] < L;
            end
            s2 = s1;
            s1 = PLL_LOCK;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        logic [N-1:0] ef, es;
        for (int i = 0; i < N; i++) begin
            ef[i] = flag[i];
            es[i] = stk[i];
        end
        chk("m_lane_reset", LANE_RESET, m_lr);
        chk("m_all_locked", ALL_LOCKED, m_all);
        chk("m_lol_flag", LOL_FLAG, ef);
        chk("m_lol_count", LOL_COUNT, m_lc);
        chk("m_stuck", STUCK, es);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tick(3);
        chk("rst_lr", LANE_RESET, 2'b11);
        chk("rst_al", ALL_LOCKED, 0);
        chk("rst_flag", LOL_FLAG, 0);
        chk("rst_cnt", LOL_COUNT, 0);
        chk("rst_stuck", STUCK, 0);
        RESET = 0;
        PLL_ENABLE = 2'b11;
        tick(1);
        // Lock both: LANE_RESET falls at edge 17, ALL_LOCKED at edge 18
        PLL_LOCK = 2'b11;
        tick(17);
        chk("lr_e16", LANE_RESET, 2'b11);
        tick(1);
        chk("lr_e17", LANE_RESET, 2'b00);
        chk("al_e17", ALL_LOCKED, 0);
        tick(1);
        chk("al_e18", ALL_LOCKED, 1);
        // Ch0 drops for 3 cycles
        PLL_LOCK = 2'b10;
        tick(2);
        chk("lol_e1", LANE_RESET, 2'b00);
        tick(1);
        chk("lol_lr", LANE_RESET, 2'b01);
        chk("lol_flag", LOL_FLAG, 2'b01);
        chk("lol_al_hold", ALL_LOCKED, 1);
        PLL_LOCK = 2'b11;
        tick(1);
        chk("lol_cnt", LOL_COUNT, 1);
        chk("lol_al_fall", ALL_LOCKED, 0);
        tick(16);
        chk("relock_pre", LANE_RESET, 2'b01);
        tick(1);
        chk("relock", LANE_RESET, 2'b00);
        CNT_SEL = 1;
        tick(1);
        chk("sel1", LOL_COUNT, 0);
        CNT_SEL = 5;
        tick(1);
        chk("sel5", LOL_COUNT, 0);
        CNT_SEL = 0;
        tick(1);
        chk("sel0", LOL_COUNT, 1);
        // Only ch0 enabled
        PLL_ENABLE = 2'b01;
        tick(1);
        chk("en01_al", ALL_LOCKED, 1);
        chk("en01_lr", LANE_RESET, 2'b10);
        // Ch1 re-qualifies, then drops inside QUAL
        PLL_ENABLE = 2'b11;
        tick(2);
        tick(10);
        PLL_LOCK = 2'b01;
        tick(3);
        chk("qdrop_lr", LANE_RESET, 2'b10);
        chk("qdrop_flag", LOL_FLAG, 2'b01);
        chk("qdrop_al", ALL_LOCKED, 0);
        CNT_SEL = 1;
        tick(1);
        chk("qdrop_cnt1", LOL_COUNT, 0);
        CNT_SEL = 0;
        // Fresh start, five 2-cycle losses on ch0 saturate the 2-bit counter
        RESET = 1;
        tick(1);
        RESET = 0;
        PLL_ENABLE = 2'b01;
        PLL_LOCK = 2'b01;
        tick(21);
        chk("sat_locked", LANE_RESET, 2'b10);
        for (int k = 0; k < 5; k++) begin
            PLL_LOCK = 2'b00;
            tick(2);
            PLL_LOCK = 2'b01;
            tick(22);
        end
        chk("sat_cnt", LOL_COUNT, 3);
        chk("sat_flag", LOL_FLAG, 2'b01);
        // Sixth loss coincident with CLR
        PLL_LOCK = 2'b00;
        tick(2);
        CLR = 1;
        PLL_LOCK = 2'b01;
        tick(1);
        CLR = 0;
        tick(1);
        chk("clr_ev_cnt", LOL_COUNT, 1);
        chk("clr_ev_flag", LOL_FLAG, 2'b01);
        tick(22);
        // Disable all: no LOL events
        PLL_ENABLE = 2'b00;
        tick(2);
        chk("dis_al", ALL_LOCKED, 0);
        chk("dis_lr", LANE_RESET, 2'b11);
        chk("dis_flag", LOL_FLAG, 2'b01);
        chk("dis_cnt", LOL_COUNT, 1);
        // Ch0 held unlocked in WAIT, ch1 locks
        PLL_ENABLE = 2'b11;
        PLL_LOCK = 2'b10;
        tick(1);
        tick(T - 1);
        chk("stuck_pre", STUCK, 2'b00);
        tick(1);
        chk("stuck", STUCK, TO ? 2'b01 : 2'b00);
        chk("stuck_lr", LANE_RESET, 2'b01);
        CLR = 1;
        tick(1);
        CLR = 0;
        chk("stuck_clr", STUCK, 2'b00);
        chk("stuck_clr_flag", LOL_FLAG, 2'b00);
        // Reset while ch0 qualifies
        PLL_LOCK = 2'b11;
        tick(6);
        chk("mid_q_lr", LANE_RESET, 2'b01);
        #3 RESET = 1;
        #1;
        chk("arst_lr", LANE_RESET, 2'b11);
        chk("arst_al", ALL_LOCKED, 0);
        chk("arst_flag", LOL_FLAG, 0);
        chk("arst_cnt", LOL_COUNT, 0);
        chk("arst_stuck", STUCK, 0);
        tick(2);
        RESET = 0;
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xcvr_pll_lock_mgr.md
# xcvr_pll_lock_mgr

Parametrised lock manager for N PolarFire transceiver TX PLLs. Synchronises each PLL's raw lock output and qualifies it over a programmable stable window. Drives a per-channel lane reset and an aggregate all-locked status, and keeps loss-of-lock statistics readable by the slow-control path. Sits between the generated TX_PLL wrappers and the transceiver lane reset logic in the ROC fabric.

## Interface
- N_PLL, 2, number of monitored PLL channels (1..8)
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-high cycles required to declare lock (>=2)
- CNT_W, 16, width of each loss-of-lock counter
- TIMEOUT_CYCLES, 65536, WAIT-state cycles before STUCK is flagged (only with PLL_LOCK_TIMEOUT_EN)

Ports:
- CLK  in  1  fabric clock; all logic in this domain
- RESET  in  1  asynchronous, active-high reset
- PLL_LOCK  in  N_PLL  raw PLL lock, asynchronous to CLK
- PLL_ENABLE  in  N_PLL  per-channel enable; 0 forces channel to IDLE
- CLR  in  1  single-cycle pulse; clears LOL_FLAG, STUCK, all counters
- CNT_SEL  in  3  channel whose counter drives LOL_COUNT
- LANE_RESET  out  N_PLL  active-high lane reset, low only in LOCKED
- ALL_LOCKED  out  1  every enabled channel LOCKED, and at least one enabled
- LOL_FLAG  out  N_PLL  sticky loss-of-lock
- LOL_COUNT  out  CNT_W  loss-of-lock count of channel CNT_SEL
- STUCK  out  N_PLL  sticky lock-timeout flag

## Operation
- Reset values: LANE_RESET all 1, ALL_LOCKED 0, LOL_FLAG 0, LOL_COUNT 0, STUCK 0, all FSMs IDLE, counters 0.
- Each PLL_LOCK bit passes through a 2-flop synchroniser to give lock_s.
- Per-channel FSM:
  - IDLE: when PLL_ENABLE=1, go to WAIT.
  - WAIT: when lock_s=1, go to QUAL with the qualify counter at 0.
  - QUAL: counter increments while lock_s=1.
    - lock_s=0 returns to WAIT, counter cleared, no LOL event.
    - counter = LOCK_STABLE_CYCLES-1 goes to LOCKED.
  - LOCKED: lock_s=0 goes to WAIT and raises a LOL event.
  - PLL_ENABLE=0 in any state goes to IDLE on the next edge. No LOL event is raised; the counter is cleared.
- LANE_RESET[n] is a registered output, 0 only while state is LOCKED.
- LOL event: LOL_FLAG[n] set; counter[n] increments, saturating at 2^CNT_W-1.
- CLR and a LOL event in the same cycle: flag ends 1 and counter ends 1; the event is never lost.
- ALL_LOCKED is registered from the AND over enabled channels of (state==LOCKED), with at least one channel enabled.
- LOL_COUNT is a registered mux of counter[CNT_SEL]. If CNT_SEL >= N_PLL, LOL_COUNT is 0.
- RESET asserted mid-operation returns everything to reset values immediately; counters are lost.

## Timing
- PLL_LOCK rises and stays high before edge 0: lock_s is high after edge 1, and the FSM enters QUAL at edge 2.
  - LOCKED is entered and LANE_RESET falls at edge 2+LOCK_STABLE_CYCLES-1.
  - ALL_LOCKED rises one edge later.
- PLL_LOCK falls before edge 0 in LOCKED: LANE_RESET rises and LOL_FLAG/counter update at edge 2, and ALL_LOCKED falls at edge 3.
- Glitches shorter than 1 CLK may be missed; glitches at least 2 CLK long in LOCKED are always counted.
- CNT_SEL change to LOL_COUNT: 1 cycle.

## Configuration
- PLL_LOCK_TIMEOUT_EN defined:
  - A per-channel WAIT-cycle counter runs while in WAIT and resets on leaving WAIT.
  - Reaching TIMEOUT_CYCLES sets STUCK[n] (sticky; cleared by CLR or RESET only). The FSM stays in WAIT.
- Not defined: no timeout logic; STUCK tied to 0. The port exists in both builds.

## Structure
- Package xcvr_pll_pkg: channel state enum (IDLE, WAIT, QUAL, LOCKED); the CNT_SEL width constant; a clog2-based qualify-counter width helper.
- Sub-module xcvr_pll_lock_chan: synchroniser, FSM, qualify counter, LOL flag/counter and optional timeout for one channel. Instantiated N_PLL times by generate.
- Top level holds the ALL_LOCKED reduction and the LOL_COUNT mux.

## Test plan
- N_PLL=2, LOCK_STABLE_CYCLES=16, both enabled, PLL_LOCK=2'b11 at edge 0 -> LANE_RESET=2'b00 at edge 17, ALL_LOCKED=1 at edge 18.
- Ch0 locked, PLL_LOCK[0] low for 3 cycles -> LANE_RESET[0]=1, LOL_FLAG[0]=1, CNT_SEL=0 gives LOL_COUNT=1; relock after 16 qualifying cycles.
- Ch1 PLL_LOCK drops after 10 cycles in QUAL -> back to WAIT, LOL_FLAG[1]=0, counter unchanged.
- CNT_W=2, 5 loss events on ch0 -> LOL_COUNT saturates at 3; CLR coincident with a 6th event -> LOL_COUNT=1, LOL_FLAG[0]=1.
- PLL_ENABLE=2'b01 with ch0 locked -> ALL_LOCKED=1; PLL_ENABLE=2'b00 -> ALL_LOCKED=0, LANE_RESET=2'b11, no LOL events.
- With PLL_LOCK_TIMEOUT_EN and TIMEOUT_CYCLES=100, PLL_LOCK held low -> STUCK[0]=1 after 100 WAIT cycles; CLR -> 0; RESET mid-QUAL -> all outputs at reset values.
